seq_detector: RTL and testbench
===============================

Name: seq_detector

Overview:
- Serial bit-pattern detector implemented as a Mealy machine. Default pattern is 0110, with overlapping matches allowed.
- Samples one input bit `x` per rising clock edge.
- Asserts `z` combinationally during the cycle in which the final bit of the pattern is present on `x`.
- Used as a standalone FSM block; a single-bit serial stream goes in and a single-bit match flag comes out.

Parameters:
- PAT_LEN, 4, pattern length in bits (legal range 2..16).
- PATTERN, 4'b0110, pattern to detect. The MSB is the first bit received; width is PAT_LEN.
- OVERLAP, 1, selects match handling:
  - 1: a match's trailing bits may start the next match.
  - 0: history is discarded after every match.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- x  input  1  serial data bit, sampled on the clk rising edge.
- z  output  1  match flag (Mealy, combinational from state and x).
- Positional port order is fixed: (x, clk, reset, z).

Behaviour:
- Reset:
  - Applies when reset = 0 at a clk rising edge.
  - Clears the history register (PAT_LEN-1 bits) to 0 and the fill counter to 0.
  - While reset = 0, z is forced to 0 regardless of x or state.
- State:
  - `hist[PAT_LEN-2:0]` holds the last PAT_LEN-1 sampled bits, newest in the LSB.
  - `fill` is a saturating count of bits taken since reset, 0..PAT_LEN-1.
- Output equation:
  - z = reset & (fill == PAT_LEN-1) & ({hist, x} == PATTERN).
  - Pure combinational path from x to z; no latency.
  - z is valid for the whole cycle preceding the edge that samples the final pattern bit.
- Update on each clk rising edge with reset = 1:
  - If OVERLAP = 1, or z = 0:
    - hist <= {hist[PAT_LEN-3:0], x}.
    - fill <= min(fill+1, PAT_LEN-1).
  - If OVERLAP = 0 and z = 1:
    - hist <= 0 and fill <= 0.
    - No bits of the matched pattern count toward the next match.
- Pattern-fill guard: no match can be reported until PAT_LEN-1 bits have been sampled after reset. The cleared history zeros must never fake a match; for example, PATTERN 0001 cannot fire on the first x = 1.
- Equivalent default-parameter FSM (implementer may code explicitly, must match the above):
  - States: S0 = nothing, S1 = "0", S2 = "01", S3 = "011".
  - S0: x=0 → S1; x=1 → S0.
  - S1: x=0 → S1; x=1 → S2.
  - S2: x=0 → S1; x=1 → S3.
  - S3: x=0 → S1 with z = 1; x=1 → S0.
- Reset mid-pattern: partial history is lost, and the pattern must be re-received in full.
- X/unknown x during reset must not propagate to z (z = 0 while reset = 0).
- Synthesizable, single clock domain, no latches, no asynchronous logic.

Test Plan:
- Reset check: hold reset = 0 for 2 cycles while x toggles → z = 0 throughout. Release, then drive x = 1,1,1 → z stays 0.
- Basic and overlapping match, default parameters:
  - After reset release, drive x per cycle: 0,0,1,1,0,1,1,0,0,1,1,0.
  - z = 1 exactly in cycles 5, 8 and 12 (1-based bit index), while x = 0 in each.
  - z = 0 in every other cycle; 3 pulses total.
- Mealy timing: in the cycle where x is the final 0 of 0110, change x to 1 mid-cycle → z drops combinationally in the same cycle, and the next state is S0.
- Non-overlap mode, OVERLAP = 0, PATTERN 0110:
  - Stream 0,1,1,0,1,1,0 → exactly one pulse, on bit 4.
  - Same stream with OVERLAP = 1 → pulses on bits 4 and 7.
- Reset mid-operation: send 0,1,1, assert reset for one edge, release, then send 0 → z = 0. Then send 0,1,1,0 → z = 1 on the final 0.
- Fill guard, PATTERN = 4'b0001: immediately after reset, send 1 → z = 0. Then send 0,0,0,1 → z = 1 on that 1.

Source files
------------

// File: rtl/seq_detector.sv
// Serial pattern detector (Mealy). Keeps the last PAT_LEN-1 bits plus a fill count so
// that a match fires combinationally on the cycle the final pattern bit sits on x.
module seq_detector #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b0110,
    parameter bit                   OVERLAP = 1'b1
) (
    input  logic x,
    input  logic clk,
    input  logic reset,
    output logic z
);

    localparam int unsigned     FW       = $clog2(PAT_LEN);
    localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] window;
    logic               full;

    always_comb begin
        window = {hist_q, x};
        full   = (fill_q == FILL_MAX);
        // Gating by full keeps the cleared history from faking a match after reset.
        z      = reset & full & (window == PATTERN);
        hist_d = window[PAT_LEN-2:0];
        fill_d = full ? fill_q : fill_q + 1'b1;
        if (!OVERLAP && z) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default, non-overlapping and 0001-pattern instances
// share one input stream; each test checks the instance(s) it targets.
module tb_seq_detector;

    logic clk;
    logic reset;
    logic x;
    logic z_d;
    logic z_n;
    logic z_g;

    int tests_run = 0;
    int tests_failed = 0;

    seq_detector u_dflt (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z_d)
    );

    seq_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b0110),
        .OVERLAP (1'b0)
    ) u_novl (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z_n)
    );

    seq_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b0001),
        .OVERLAP (1'b1)
    ) u_g0001 (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Present one bit just after a rising edge, then wait to the falling edge to sample z.
    task automatic drive(input logic b);
        @(posedge clk);
        #1;
        reset = 1'b1;
        x     = b;
        @(negedge clk);
    endtask

    // Hold reset low for the given number of edges while x toggles; z must stay 0.
    task automatic do_reset(input int edges, input string tag);
        for (int i = 0; i < edges; i++) begin
            if (i > 0) @(posedge clk);
            else @(posedge clk);
            #1;
            reset = 1'b0;
            x     = (i % 2 == 0) ? 1'b1 : 1'bx;
            @(negedge clk);
            check_bit({tag, "_dflt"}, z_d, 1'b0);
            check_bit({tag, "_novl"}, z_n, 1'b0);
            check_bit({tag, "_g0001"}, z_g, 1'b0);
            x = 1'b0;
            #1;
            check_bit({tag, "_x0_dflt"}, z_d, 1'b0);
        end
    endtask

    // Bits and expectations are MSB-first: bit n-1 is sent first.
    task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] exp_d, input logic [15:0] exp_n,
                           input logic [15:0] exp_g);
        for (int i = n - 1; i >= 0; i--) begin
            drive(bits[i]);
            check_bit($sformatf("%s_b%0d_dflt", tag, n - i), z_d, exp_d[i]);
            check_bit($sformatf("%s_b%0d_novl", tag, n - i), z_n, exp_n[i]);
            check_bit($sformatf("%s_b%0d_g0001", tag, n - i), z_g, exp_g[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        x     = 1'b0;

        // Reset held for two edges, then 1,1,1 gives nothing.
        do_reset(2, "rst");
        run_seq("ones", 3, 16'b111, 16'b000, 16'b000, 16'b000);

        // Overlapping stream: default fires on 5,8,12; non-overlap loses bit 8.
        do_reset(2, "rst2");
        run_seq("ovl", 12, 16'b0011_0110_0110, 16'b0000_1001_0001,
                16'b0000_1000_0001, 16'b0000_0000_0000);

        // Mealy timing: final 0 raises z, flipping x to 1 mid-cycle drops it at once.
        do_reset(2, "rst3");
        run_seq("pre", 3, 16'b011, 16'b000, 16'b000, 16'b000);
        @(posedge clk);
        #1;
        x = 1'b0;
        #2;
        check_bit("mealy_hi", z_d, 1'b1);
        x = 1'b1;
        #1;
        check_bit("mealy_lo", z_d, 1'b0);
        check_bit("mealy_lo_novl", z_n, 1'b0);
        // History now 111: a fresh 0110 is needed for the next pulse.
        run_seq("post", 4, 16'b0110, 16'b0001, 16'b0001, 16'b0000);

        // Non-overlap vs overlap on 0110110.
        do_reset(2, "rst4");
        run_seq("novl", 7, 16'b0110110, 16'b0001001, 16'b0001000, 16'b0000000);

        // Reset mid-pattern discards 011.
        do_reset(2, "rst5");
        run_seq("part", 3, 16'b011, 16'b000, 16'b000, 16'b000);
        do_reset(1, "mid");
        run_seq("after", 1, 16'b0, 16'b0, 16'b0, 16'b0);
        run_seq("refill", 4, 16'b0110, 16'b0001, 16'b0001, 16'b0000);

        // Fill guard: zeroed history must not fake 0001 on the first 1.
        do_reset(2, "rst6");
        run_seq("guard", 1, 16'b1, 16'b0, 16'b0, 16'b0);
        run_seq("g0001", 4, 16'b0001, 16'b0000, 16'b0000, 16'b0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
